alu_share_ctrl: RTL and testbench

Sequencer and arbiter that shares the single 32-bit combinational ALU (3-bit ALUOp, operands A/B, result C) between two requesters. It accepts one operation at a time over valid/ready handshakes with round-robin fairness, registers the operands, and drives the ALU for one execute cycle. It normalises shift amounts, captures the result, and returns it on a shared response channel with backpressure. It sits between the issuing logic (requester 0, requester 1) and the ALU instance.

---
 rtl/alu_share_ctrl.sv | 130 +++++++++++++
 tb/tb_alu_share_ctrl.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: lets two requesters take turns on one shared 32-bit ALU.
// Requests come in over valid/ready handshakes and a round-robin arbiter
// chooses between them. The block registers the operands, runs the ALU for
// one cycle and returns the result with backpressure. Shift amounts are
// trimmed to 5 bits. Illegal opcodes are turned into a zeroed add and
// flagged as an error.
//
// state | meaning
// IDLE  | arbitrate; accept one request from the winner
// EXEC  | registered operands drive the ALU; capture result at cycle end
// RESP  | response presented; hold until rsp_ready
module alu_share_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [2:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [2:0]  req1_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_op,
  input  logic [31:0] alu_c,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        last_grant;
  logic        grant0;
  logic        grant1;
  logic        accept;
  logic        sel;
  logic [31:0] sel_a;
  logic [31:0] sel_b;
  logic [2:0]  sel_op;
  logic        sel_illegal;
  logic        sel_shift;

  // Round-robin arbitration: on a tie, the requester not granted last wins.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE) begin
      if (req0_valid && req1_valid) begin
        grant0 = last_grant;
        grant1 = !last_grant;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign req0_ready  = grant0;
  assign req1_ready  = grant1;
  assign accept      = grant0 | grant1;
  assign sel         = grant1;
  assign sel_a       = sel ? req1_a  : req0_a;
  assign sel_b       = sel ? req1_b  : req0_b;
  assign sel_op      = sel ? req1_op : req0_op;
  assign sel_illegal = sel_op[2] & sel_op[1];
  assign sel_shift   = sel_op[2] & ~sel_op[1];

  // Next-state logic for the request/execute/response sequence.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Latch the winner's operands (normalised) on accept, and the result at the end of EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a      <= 32'd0;
      alu_b      <= 32'd0;
      alu_op     <= 3'd0;
      rsp_id     <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_data   <= 32'd0;
      last_grant <= 1'b1;
    end else begin
      if (accept) begin
        rsp_id     <= sel;
        rsp_err    <= sel_illegal;
        last_grant <= sel;
        if (sel_illegal) begin
          alu_a  <= 32'd0;
          alu_b  <= 32'd0;
          alu_op <= 3'd0;
        end else begin
          alu_a  <= sel_a;
          alu_b  <= sel_shift ? {27'd0, sel_b[4:0]} : sel_b;
          alu_op <= sel_op;
        end
      end
      if (state == EXEC) rsp_data <= rsp_err ? 32'd0 : alu_c;
    end
  end

  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: a behavioural ALU answers the DUT, and a small
// reference model predicts the arbitration winners and the results.
module tb_alu_share_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_op, req1_op;
  logic [31:0] alu_a, alu_b, alu_c;
  logic [2:0]  alu_op;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
  logic [31:0] rsp_data;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int mlast;

  // results of the most recent run_op
  int          o_gnt, o_wait, o_cyc, o_lat, o_rcyc;
  logic        o_rid, o_rerr;
  logic [31:0] o_rdata, o_alu_a, o_alu_b;
  logic [2:0]  o_alu_op;
  bit          o_busy_ok, o_stall_ok, o_idle_after;

  alu_share_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c(alu_c),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // the shared ALU sitting outside the DUT
  always_comb begin
    case (alu_op)
      3'd0:    alu_c = alu_a + alu_b;
      3'd1:    alu_c = alu_a - alu_b;
      3'd2:    alu_c = alu_a & alu_b;
      3'd3:    alu_c = alu_a | alu_b;
      3'd4:    alu_c = alu_a >> alu_b;
      3'd5:    alu_c = 32'($signed(alu_a) >>> alu_b);
      default: alu_c = 32'd0;
    endcase
  end

  // expected {err, data} for a request as issued by a requester
  function automatic logic [32:0] ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    case (op)
      3'd0:    return {1'b0, a + b};
      3'd1:    return {1'b0, a - b};
      3'd2:    return {1'b0, a & b};
      3'd3:    return {1'b0, a | b};
      3'd4:    return {1'b0, a >> sh};
      3'd5:    return {1'b0, 32'($signed(a) >>> sh)};
      default: return {1'b1, 32'd0};
    endcase
  endfunction

  function automatic int exp_winner(input bit v0, input bit v1);
    if (v0 && v1) return (mlast == 1) ? 0 : 1;
    return v0 ? 0 : 1;
  endfunction

  // Present a request (or two), wait for the grant, and then observe EXEC and
  // RESP. rsp_ready is held low for 'stall' RESP cycles. The task returns on
  // the negedge of the IDLE cycle that follows. It only records what it sees;
  // the callers do the checking.
  task automatic run_op(input bit v0, input bit v1,
                        input logic [31:0] a0, input logic [31:0] b0, input logic [2:0] op0,
                        input logic [31:0] a1, input logic [31:0] b1, input logic [2:0] op1,
                        input int stall);
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = op0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = op1;
    rsp_ready  = (stall == 0);
    o_gnt = -1; o_wait = 0; o_lat = -1; o_rcyc = 0;
    o_busy_ok = 1; o_stall_ok = 1; o_idle_after = 0;
    #1;
    for (int w = 0; w < 8; w++) begin
      if (req0_ready || req1_ready) begin
        o_gnt = (req0_ready && req1_ready) ? 2 : (req1_ready ? 1 : 0);
        o_cyc = cyc;
        break;
      end
      o_wait++;
      @(negedge clk); #1;
    end
    if (o_gnt < 0) begin
      req0_valid = 0; req1_valid = 0;
      @(negedge clk);
      return;
    end
    @(negedge clk);
    o_alu_a = alu_a; o_alu_b = alu_b; o_alu_op = alu_op;
    if (busy !== 1'b1 || rsp_valid !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) o_busy_ok = 0;
    for (int k = 2; k < 20; k++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        o_lat = k;
        break;
      end
    end
    if (o_lat < 0) begin
      req0_valid = 0; req1_valid = 0;
      return;
    end
    o_rid = rsp_id; o_rdata = rsp_data; o_rerr = rsp_err;
    for (int k = 0; k < stall + 10; k++) begin
      rsp_ready = (k >= stall);
      #1;
      o_rcyc++;
      if (rsp_valid !== 1'b1 || rsp_id !== o_rid || rsp_data !== o_rdata || rsp_err !== o_rerr ||
          req0_ready !== 1'b0 || req1_ready !== 1'b0 || busy !== 1'b1) o_stall_ok = 0;
      @(negedge clk);
      if (rsp_ready) break;
    end
    o_idle_after = (busy === 1'b0 && rsp_valid === 1'b0);
    req0_valid = 0; req1_valid = 0;
  endtask

  task automatic test_reset;
    rst_n = 0;
    rsp_ready = 1;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if ({req0_ready, req1_ready, rsp_valid, busy, rsp_id, rsp_err} !== 6'b0) begin
      n_err++; $display("FAIL reset_ctrl: got %b expected 000000", {req0_ready, req1_ready, rsp_valid, busy, rsp_id, rsp_err});
    end
    n_cmp++;
    if (alu_a !== 32'd0 || alu_b !== 32'd0) begin
      n_err++; $display("FAIL reset_alu_ab: got %h/%h expected 0/0", alu_a, alu_b);
    end
    n_cmp++;
    if (alu_op !== 3'd0) begin
      n_err++; $display("FAIL reset_alu_op: got %0d expected 0", alu_op);
    end
    n_cmp++;
    if (rsp_data !== 32'd0) begin
      n_err++; $display("FAIL reset_rsp_data: got %h expected 0", rsp_data);
    end
    @(negedge clk);
    rst_n = 1;
    mlast = 1;
    @(negedge clk);
    #1;
    n_cmp++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL post_reset_idle: got busy=%b rsp_valid=%b expected 0/0", busy, rsp_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_round_robin;
    int prev;
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      run_op(1, 1, 32'd10, 32'd3, 3'd1, 32'd10, 32'd3, 3'd1, 0);
      n_cmp++;
      if (o_gnt !== (i % 2)) begin
        n_err++; $display("FAIL rr_grant[%0d]: got %0d expected %0d", i, o_gnt, i % 2);
      end
      n_cmp++;
      if (o_rdata !== 32'd7 || o_rid !== 1'(i % 2) || o_rerr !== 1'b0) begin
        n_err++; $display("FAIL rr_rsp[%0d]: got data=%h id=%b err=%b expected 7/%0d/0", i, o_rdata, o_rid, o_rerr, i % 2);
      end
      if (i > 0) begin
        n_cmp++;
        if (o_cyc - prev != 3) begin
          n_err++; $display("FAIL rr_interval[%0d]: got %0d expected 3", i, o_cyc - prev);
        end
      end
      prev = o_cyc;
      mlast = i % 2;
    end
  endtask

  task automatic test_single_op;
    run_op(1, 0, 32'hFFFF_FFFF, 32'd2, 3'd0, 32'd0, 32'd0, 3'd0, 0);
    n_cmp++;
    if (o_gnt !== 0 || o_wait !== 0) begin
      n_err++; $display("FAIL single_grant: got gnt=%0d wait=%0d expected 0/0", o_gnt, o_wait);
    end
    n_cmp++;
    if (o_lat !== 2) begin
      n_err++; $display("FAIL single_latency: got %0d expected 2", o_lat);
    end
    n_cmp++;
    if (o_rdata !== 32'h0000_0001 || o_rid !== 1'b0 || o_rerr !== 1'b0) begin
      n_err++; $display("FAIL single_rsp: got data=%h id=%b err=%b expected 00000001/0/0", o_rdata, o_rid, o_rerr);
    end
    n_cmp++;
    if (!o_busy_ok || !o_stall_ok || !o_idle_after) begin
      n_err++; $display("FAIL single_busy: got exec=%b resp=%b idle=%b expected 1/1/1", o_busy_ok, o_stall_ok, o_idle_after);
    end
    mlast = 0;
  endtask

  task automatic test_shift;
    run_op(0, 1, 32'd0, 32'd0, 3'd0, 32'h8000_0000, 32'h0000_0024, 3'd5, 0);
    n_cmp++;
    if (o_alu_b !== 32'd4 || o_alu_op !== 3'd5 || o_alu_a !== 32'h8000_0000) begin
      n_err++; $display("FAIL shift_norm: got a=%h b=%h op=%0d expected 80000000/4/5", o_alu_a, o_alu_b, o_alu_op);
    end
    n_cmp++;
    if (o_rdata !== 32'hF800_0000 || o_rid !== 1'b1 || o_gnt !== 1) begin
      n_err++; $display("FAIL shift_rsp: got data=%h id=%b gnt=%0d expected F8000000/1/1", o_rdata, o_rid, o_gnt);
    end
    mlast = 1;
  endtask

  task automatic test_illegal;
    run_op(1, 0, 32'd5, 32'd6, 3'd7, 32'd0, 32'd0, 3'd0, 0);
    n_cmp++;
    if (o_alu_op !== 3'd0 || o_alu_a !== 32'd0 || o_alu_b !== 32'd0) begin
      n_err++; $display("FAIL illegal_alu: got a=%h b=%h op=%0d expected 0/0/0", o_alu_a, o_alu_b, o_alu_op);
    end
    n_cmp++;
    if (o_rdata !== 32'd0 || o_rerr !== 1'b1) begin
      n_err++; $display("FAIL illegal_rsp: got data=%h err=%b expected 0/1", o_rdata, o_rerr);
    end
    run_op(1, 0, 32'd5, 32'd6, 3'd3, 32'd0, 32'd0, 3'd0, 0);
    n_cmp++;
    if (o_rdata !== 32'd7 || o_rerr !== 1'b0) begin
      n_err++; $display("FAIL legal_after_illegal: got data=%h err=%b expected 7/0", o_rdata, o_rerr);
    end
    mlast = 0;
  endtask

  task automatic test_backpressure;
    int exp;
    logic [32:0] r;
    exp = exp_winner(1, 1);
    r = (exp == 1) ? ref_op(3'd0, 32'h1234_5678, 32'h1111_1111) : ref_op(3'd2, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    run_op(1, 1, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'd2, 32'h1234_5678, 32'h1111_1111, 3'd0, 5);
    n_cmp++;
    if (o_gnt !== exp) begin
      n_err++; $display("FAIL bp_grant: got %0d expected %0d", o_gnt, exp);
    end
    n_cmp++;
    if (o_rcyc !== 6 || !o_stall_ok) begin
      n_err++; $display("FAIL bp_hold: got cycles=%0d stable=%b expected 6/1", o_rcyc, o_stall_ok);
    end
    n_cmp++;
    if ({o_rerr, o_rdata} !== r || o_rid !== 1'(exp)) begin
      n_err++; $display("FAIL bp_rsp: got %h id=%b expected %h id=%0d", {o_rerr, o_rdata}, o_rid, r, exp);
    end
    n_cmp++;
    if (!o_idle_after) begin
      n_err++; $display("FAIL bp_idle_after: got 0 expected 1");
    end
    mlast = exp;
  endtask

  task automatic test_reset_mid_op;
    bit stale;
    stale = 0;
    req0_valid = 1; req0_a = 32'h0000_00AA; req0_b = 32'h0000_0055; req0_op = 3'd0;
    rsp_ready = 1;
    #1;
    n_cmp++;
    if (req0_ready !== 1'b1) begin
      n_err++; $display("FAIL midrst_accept: got %b expected 1", req0_ready);
    end
    @(negedge clk);
    req0_valid = 0;
    #2 rst_n = 0;
    #1;
    n_cmp++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || alu_a !== 32'd0 || alu_b !== 32'd0 || alu_op !== 3'd0) begin
      n_err++; $display("FAIL midrst_clear: got rv=%b busy=%b a=%h b=%h op=%0d expected all 0", rsp_valid, busy, alu_a, alu_b, alu_op);
    end
    repeat (2) @(negedge clk);
    rst_n = 1;
    mlast = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || busy !== 1'b0) stale = 1;
    end
    n_cmp++;
    if (stale) begin
      n_err++; $display("FAIL midrst_stale: got a response or busy after reset expected none");
    end
    run_op(1, 1, 32'd1, 32'd1, 3'd0, 32'd2, 32'd2, 3'd0, 0);
    n_cmp++;
    if (o_gnt !== 0 || o_rdata !== 32'd2) begin
      n_err++; $display("FAIL midrst_tie: got gnt=%0d data=%h expected 0/2", o_gnt, o_rdata);
    end
    mlast = 0;
  endtask

  task automatic test_random;
    for (int i = 0; i < 40; i++) begin
      logic [1:0]  vs;
      logic [31:0] a0, b0, a1, b1;
      logic [2:0]  op0, op1;
      logic [32:0] r;
      int          stall, exp;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      vs  = 2'($urandom_range(1, 3));
      a0  = $urandom; b0 = $urandom; op0 = 3'($urandom_range(0, 7));
      a1  = $urandom; b1 = $urandom; op1 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) a0 = 32'hFFFF_FFFF;
      if ($urandom_range(0, 3) == 0) b1 = 32'hFFFF_FFFF;
      stall = $urandom_range(0, 3);
      exp = exp_winner(vs[0], vs[1]);
      r = (exp == 1) ? ref_op(op1, a1, b1) : ref_op(op0, a0, b0);
      run_op(vs[0], vs[1], a0, b0, op0, a1, b1, op1, stall);
      n_cmp++;
      if (o_gnt !== exp || o_lat !== 2) begin
        n_err++; $display("FAIL rand_grant[%0d]: got gnt=%0d lat=%0d expected %0d/2", i, o_gnt, o_lat, exp);
      end
      n_cmp++;
      if ({o_rerr, o_rdata} !== r || o_rid !== 1'(exp)) begin
        n_err++; $display("FAIL rand_rsp[%0d]: got %h id=%b expected %h id=%0d", i, {o_rerr, o_rdata}, o_rid, r, exp);
      end
      n_cmp++;
      if (!o_stall_ok || o_rcyc !== stall + 1) begin
        n_err++; $display("FAIL rand_hold[%0d]: got stable=%b cycles=%0d expected 1/%0d", i, o_stall_ok, o_rcyc, stall + 1);
      end
      mlast = exp;
    end
  endtask

  initial begin
    rst_n = 0;
    req0_valid = 0; req0_a = 0; req0_b = 0; req0_op = 0;
    req1_valid = 0; req1_a = 0; req1_b = 0; req1_op = 0;
    rsp_ready = 0;
    mlast = 1;
    test_reset;
    test_round_robin;
    test_single_op;
    test_shift;
    test_illegal;
    test_backpressure;
    test_reset_mid_op;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
